// File: rtl/commit_trace_fifo_pkg.sv
// Shared types and constants for the commit trace capture block.
// commit_entry_t is the record stored per captured commit. Its seq field is
// sized for the widest supported tag (32 bits); narrower tags are
// zero-extended on the way in and truncated on the way out.
package commit_trace_pkg;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int SEQ_MAX_W = 32;

  typedef struct packed {
    logic [SEQ_MAX_W-1:0] seq;
    logic [XLEN-1:0]      pc;
    logic [REG_AW-1:0]    rd;
    logic [XLEN-1:0]      data;
  } commit_entry_t;

endpackage

// File: rtl/commit_trace_fifo_if.sv
// Bundle of the commit-side, drain-side and status signals of
// commit_trace_fifo.
//   master : the core/consumer side (drives commit_*, trace_ready, clear)
//   slave  : the capture block (drives trace_*, level, overflow, drop_count)
// Drain handshake: an entry transfers on a rising clk edge where
// trace_valid && trace_ready. While trace_valid && !trace_ready the trace_*
// payload holds steady. trace_ready while trace_valid=0 has no effect.
interface commit_trace_fifo_if #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
);
  import commit_trace_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                commit_valid;
  logic [XLEN-1:0]     commit_pc;
  logic [REG_AW-1:0]   commit_rd;
  logic [XLEN-1:0]     commit_data;

  logic                trace_valid;
  logic                trace_ready;
  logic [SEQ_W-1:0]    trace_seq;
  logic [XLEN-1:0]     trace_pc;
  logic [REG_AW-1:0]   trace_rd;
  logic [XLEN-1:0]     trace_data;

  logic [LVL_W-1:0]    level;
  logic                overflow;
  logic [SEQ_W-1:0]    drop_count;
  logic                clear;

  modport master (
    output commit_valid, commit_pc, commit_rd, commit_data,
    output trace_ready, clear,
    input  trace_valid, trace_seq, trace_pc, trace_rd, trace_data,
    input  level, overflow, drop_count
  );

  modport slave (
    input  commit_valid, commit_pc, commit_rd, commit_data,
    input  trace_ready, clear,
    output trace_valid, trace_seq, trace_pc, trace_rd, trace_data,
    output level, overflow, drop_count
  );

endinterface

// File: rtl/commit_trace_fifo_sync_fifo.sv
// trace_sync_fifo: single-clock show-ahead FIFO of commit_entry_t.
// The head entry lives in a dedicated register (head_o) so the output has no
// combinational path from the push side and holds its last value once empty.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   push_i/data_i  write request and entry (ignored when full unless popping)
//   pop_i          remove head (ignored when empty)
//   full_o/empty_o occupancy flags
//   level_o        occupancy 0..DEPTH
//   head_o         current head entry (valid when !empty_o)
module trace_sync_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  commit_entry_t              data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output commit_entry_t              head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  commit_entry_t   mem [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  commit_entry_t   head_q, head_d;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign level_o = cnt_q;
  assign head_o  = head_q;

  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d   = wr_q + AW'(do_push);
    rd_d   = rd_q + AW'(do_pop);
    cnt_d  = cnt_q;
    head_d = head_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Next head is the slot rd_d points at; if that slot is being written
    // this cycle (the new entry becomes the only one) forward the push data.
    if (cnt_d != '0) begin
      if (do_push && (wr_q == rd_d)) head_d = data_i;
      else                           head_d = mem[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: captures qualifying retirement commits into a bounded
// FIFO, tags each with a sequence number and presents them on a valid/ready
// drain port. Commits that arrive while the FIFO is full are dropped; the
// sequence counter still advances so the consumer sees a gap in trace_seq,
// and overflow/drop_count record that the trace is incomplete.
// Ports:
//   clk    rising-edge clock (core clock)
//   reset  asynchronous, active-low
//   bus    commit_trace_fifo_if.slave: commit_*, trace_*, level, overflow,
//          drop_count, clear
module commit_trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter bit KEEP_X0 = 1'b0,
  parameter int SEQ_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  commit_trace_fifo_if.slave    bus
);

  logic             qualify, pop, push, drop, full, empty;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d;
  logic [SEQ_W-1:0] drop_cnt_q, drop_cnt_d;
  commit_entry_t    wr_entry, head;

  assign qualify = bus.commit_valid && (KEEP_X0 || (bus.commit_rd != '0));
  assign pop     = !empty && bus.trace_ready;
  assign push    = qualify && (!full || pop);
  assign drop    = qualify && !push;

  // Pushed entries carry the pre-increment tag.
  always_comb begin
    wr_entry      = '0;
    wr_entry.seq  = SEQ_MAX_W'(seq_q);
    wr_entry.pc   = bus.commit_pc;
    wr_entry.rd   = bus.commit_rd;
    wr_entry.data = bus.commit_data;
  end

  always_comb begin
    seq_d      = seq_q + SEQ_W'(qualify);
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      // A drop coinciding with clear wins: the count restarts at one.
      ovf_d = 1'b1;
      if (bus.clear)                drop_cnt_d = SEQ_W'(1);
      else if (drop_cnt_q != '1)    drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (bus.clear) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      seq_q      <= seq_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  trace_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .level_o (bus.level),
    .head_o  (head)
  );

  assign bus.trace_valid = !empty;
  assign bus.trace_seq   = head.seq[SEQ_W-1:0];
  assign bus.trace_pc    = head.pc;
  assign bus.trace_rd    = head.rd;
  assign bus.trace_data  = head.data;
  assign bus.overflow    = ovf_q;
  assign bus.drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed and randomized checks of commit_trace_fifo against a queue-based
// reference model (DEPTH=16, KEEP_X0=0, SEQ_W=16).
module tb_commit_trace_fifo;
  import commit_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int SEQ_W = 16;

  typedef struct {
    int          seq;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ref_entry_t;

  logic clk;
  logic reset;
  commit_trace_fifo_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) bus ();

  commit_trace_fifo #(.DEPTH(DEPTH), .KEEP_X0(1'b0), .SEQ_W(SEQ_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  ref_entry_t m_q[$];
  int         m_seq;
  int         m_drops;
  bit         m_ovf;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_seq   = 0;
    m_drops = 0;
    m_ovf   = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, 64'(bus.trace_valid), 64'(m_q.size() != 0));
    chk({tag, "_level"}, 64'(bus.level), 64'(m_q.size()));
    chk({tag, "_ovf"},   64'(bus.overflow), 64'(m_ovf));
    chk({tag, "_drops"}, 64'(bus.drop_count), 64'(m_drops));
    if (m_q.size() != 0) begin
      chk({tag, "_seq"},  64'(bus.trace_seq), 64'(m_q[0].seq));
      chk({tag, "_pc"},   64'(bus.trace_pc), 64'(m_q[0].pc));
      chk({tag, "_rd"},   64'(bus.trace_rd), 64'(m_q[0].rd));
      chk({tag, "_data"}, 64'(bus.trace_data), 64'(m_q[0].data));
    end
  endtask

  // One clock: drive inputs, predict from the pre-edge model, check after edge.
  task automatic step(input string tag, input bit cv, input logic [31:0] pc,
                      input logic [4:0] rd, input logic [31:0] data,
                      input bit rdy, input bit clr);
    bit qual, pop, push;
    ref_entry_t e;
    bus.commit_valid = cv;
    bus.commit_pc    = pc;
    bus.commit_rd    = rd;
    bus.commit_data  = data;
    bus.trace_ready  = rdy;
    bus.clear        = clr;
    qual = cv && (rd != 0);
    pop  = (m_q.size() != 0) && rdy;
    push = qual && ((m_q.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.seq = m_seq; e.pc = pc; e.rd = rd; e.data = data;
      m_q.push_back(e);
    end
    if (qual && !push) begin
      m_ovf = 1;
      if (clr)                  m_drops = 1;
      else if (m_drops < 65535) m_drops++;
    end else if (clr) begin
      m_ovf   = 0;
      m_drops = 0;
    end
    if (qual) m_seq = (m_seq + 1) % 65536;
    check_state(tag);
  endtask

  task automatic idle(input string tag, input bit rdy);
    step(tag, 1'b0, 32'h0, 5'd0, 32'h0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    bus.commit_valid = 0; bus.commit_pc = 0; bus.commit_rd = 0;
    bus.commit_data = 0; bus.trace_ready = 0; bus.clear = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  logic [SEQ_W-1:0] snap_seq;
  logic [31:0]      snap_pc, snap_data;
  logic [4:0]       snap_rd;

  initial begin
    model_reset();
    do_reset();
    // reset values
    chk("rst_valid", 64'(bus.trace_valid), 64'd0);
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_ovf",   64'(bus.overflow), 64'd0);
    chk("rst_drops", 64'(bus.drop_count), 64'd0);
    chk("rst_seq",   64'(bus.trace_seq), 64'd0);
    chk("rst_pc",    64'(bus.trace_pc), 64'd0);
    chk("rst_data",  64'(bus.trace_data), 64'd0);

    // single commit, one-cycle latency
    step("single", 1'b1, 32'h100, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("single_valid", 64'(bus.trace_valid), 64'd1);
    chk("single_seq",   64'(bus.trace_seq), 64'd0);
    chk("single_pc",    64'(bus.trace_pc), 64'h100);
    chk("single_rd",    64'(bus.trace_rd), 64'd5);
    chk("single_data",  64'(bus.trace_data), 64'hDEADBEEF);
    idle("single_pop", 1'b1);
    chk("single_lvl0", 64'(bus.level), 64'd0);

    // fill beyond capacity with no consumer
    do_reset();
    for (int i = 0; i < 18; i++)
      step("fill", 1'b1, 32'h1000 + 32'(i * 4), 5'd1, $urandom, 1'b0, 1'b0);
    chk("fill_level", 64'(bus.level), 64'd16);
    chk("fill_ovf",   64'(bus.overflow), 64'd1);
    chk("fill_drops", 64'(bus.drop_count), 64'd2);
    for (int i = 0; i < 16; i++) begin
      chk("drain_seq", 64'(bus.trace_seq), 64'(i));
      idle("drain", 1'b1);
    end
    step("after_gap", 1'b1, 32'h2000, 5'd1, 32'h55, 1'b0, 1'b0);
    chk("after_gap_seq", 64'(bus.trace_seq), 64'd18);
    idle("after_gap_pop", 1'b1);

    // full FIFO with simultaneous commit and pop
    do_reset();
    for (int i = 0; i < 16; i++)
      step("full_fill", 1'b1, 32'h3000 + 32'(i), 5'd2, $urandom, 1'b0, 1'b0);
    step("full_swap", 1'b1, 32'h3100, 5'd2, 32'hABCD, 1'b1, 1'b0);
    chk("full_swap_lvl",  64'(bus.level), 64'd16);
    chk("full_swap_drop", 64'(bus.drop_count), 64'd0);
    chk("full_swap_seq",  64'(bus.trace_seq), 64'd1);

    // clear in the same cycle as a drop
    step("drop1", 1'b1, 32'h3200, 5'd2, 32'h1, 1'b0, 1'b0);
    step("drop2", 1'b1, 32'h3204, 5'd2, 32'h2, 1'b0, 1'b0);
    chk("drop2_cnt", 64'(bus.drop_count), 64'd2);
    step("drop_clr", 1'b1, 32'h3208, 5'd2, 32'h3, 1'b0, 1'b1);
    chk("drop_clr_ovf", 64'(bus.overflow), 64'd1);
    chk("drop_clr_cnt", 64'(bus.drop_count), 64'd1);
    step("clr_only", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1);
    chk("clr_only_ovf", 64'(bus.overflow), 64'd0);
    chk("clr_only_lvl", 64'(bus.level), 64'd16);

    // rd=0 commits interleaved with rd=3
    do_reset();
    for (int i = 0; i < 10; i++)
      step("x0", 1'b1, 32'h4000 + 32'(i * 4), (i % 2 == 0) ? 5'd0 : 5'd3, $urandom, 1'b0, 1'b0);
    chk("x0_level", 64'(bus.level), 64'd5);
    chk("x0_drops", 64'(bus.drop_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("x0_seq", 64'(bus.trace_seq), 64'(i));
      chk("x0_rd",  64'(bus.trace_rd), 64'd3);
      idle("x0_drain", 1'b1);
    end

    // backpressure stability
    do_reset();
    for (int i = 0; i < 3; i++)
      step("bp_fill", 1'b1, 32'h5000 + 32'(i * 4), 5'd7, $urandom, 1'b0, 1'b0);
    snap_seq = bus.trace_seq; snap_pc = bus.trace_pc;
    snap_rd = bus.trace_rd; snap_data = bus.trace_data;
    for (int i = 0; i < 5; i++) begin
      idle("bp_hold", 1'b0);
      chk("bp_seq",  64'(bus.trace_seq), 64'(snap_seq));
      chk("bp_pc",   64'(bus.trace_pc), 64'(snap_pc));
      chk("bp_rd",   64'(bus.trace_rd), 64'(snap_rd));
      chk("bp_data", 64'(bus.trace_data), 64'(snap_data));
    end
    for (int i = 0; i < 3; i++) idle("bp_release", 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step("rand", ($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 3)),
           $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));

    // async reset mid-stream at level 7
    do_reset();
    for (int i = 0; i < 7; i++)
      step("pre_rst", 1'b1, 32'h6000 + 32'(i * 4), 5'd9, $urandom, 1'b0, 1'b0);
    chk("pre_rst_lvl", 64'(bus.level), 64'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("async_lvl",   64'(bus.level), 64'd0);
    chk("async_valid", 64'(bus.trace_valid), 64'd0);
    chk("async_seq",   64'(bus.trace_seq), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("post_rst", 1'b1, 32'h7000, 5'd4, 32'h77, 1'b0, 1'b0);
    chk("post_rst_seq", 64'(bus.trace_seq), 64'd0);
    idle("post_rst_pop", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
